// File: rtl/acia_tx.sv
// 8N1 serial transmitter (LSB first, idle high) with a small write FIFO.
// Frames are sent back-to-back while the FIFO has data; all bit timing advances on pclk.
module acia_tx #(
   parameter int SCW     = 9,
   parameter int sym_cnt = 417,
   parameter int FAW     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pclk,
   input  logic [7:0] tx_dat,
   input  logic       tx_start,
   output logic       tx_serial,
   output logic       tx_busy,
   output logic       tx_empty,
   output logic       tx_full,
   output logic       tx_ovr
);

   localparam int DEPTH = 2 ** FAW;
   localparam logic [FAW:0]   FULL_OCC = (FAW + 1)'(DEPTH);
   localparam logic [SCW-1:0] RLOAD    = SCW'(sym_cnt - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]     mem [DEPTH];
   logic [FAW-1:0] wr_ptr, rd_ptr;
   logic [FAW:0]   occ, occ_nxt;
   logic           wr_en, pop;

   state_t         state, state_nxt;
   logic [SCW-1:0] rcnt, rcnt_nxt;
   logic [2:0]     bcnt, bcnt_nxt;
   logic [7:0]     shreg, shreg_nxt;
   logic           serial_nxt, busy_nxt;

   // A write is judged against the registered full flag, so a same-cycle pop cannot rescue it
   always_comb begin
      wr_en   = tx_start & ~tx_full;
      occ_nxt = occ;
      case ({wr_en, pop})
         2'b10:   occ_nxt = occ + 1'b1;
         2'b01:   occ_nxt = occ - 1'b1;
         default: occ_nxt = occ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= tx_dat;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         tx_empty <= 1'b1;
         tx_full  <= 1'b0;
         tx_ovr   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         occ      <= occ_nxt;
         tx_empty <= (occ_nxt == '0);
         tx_full  <= (occ_nxt == FULL_OCC);
         if (tx_start & tx_full) tx_ovr <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rcnt      <= '0;
         bcnt      <= '0;
         shreg     <= '0;
         tx_serial <= 1'b1;
         tx_busy   <= 1'b0;
      end else begin
         state     <= state_nxt;
         rcnt      <= rcnt_nxt;
         bcnt      <= bcnt_nxt;
         shreg     <= shreg_nxt;
         tx_serial <= serial_nxt;
         tx_busy   <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      rcnt_nxt   = rcnt;
      bcnt_nxt   = bcnt;
      shreg_nxt  = shreg;
      serial_nxt = tx_serial;
      busy_nxt   = tx_busy;
      pop        = 1'b0;
      if (pclk) begin
         case (state)
            IDLE: begin
               if (!tx_empty) begin
                  pop        = 1'b1;
                  shreg_nxt  = mem[rd_ptr];
                  serial_nxt = 1'b0;
                  busy_nxt   = 1'b1;
                  rcnt_nxt   = RLOAD;
                  state_nxt  = START;
               end
            end
            default: begin
               if (rcnt != '0) begin
                  rcnt_nxt = rcnt - 1'b1;
               end else begin
                  rcnt_nxt = RLOAD;
                  case (state)
                     START: begin
                        serial_nxt = shreg[0];
                        bcnt_nxt   = 3'd7;
                        state_nxt  = DATA;
                     end
                     DATA: begin
                        if (bcnt == '0) begin
                           serial_nxt = 1'b1;
                           state_nxt  = STOP;
                        end else begin
                           shreg_nxt  = {1'b0, shreg[7:1]};
                           serial_nxt = shreg[1];
                           bcnt_nxt   = bcnt - 1'b1;
                        end
                     end
                     STOP: begin
                        if (!tx_empty) begin
                           pop        = 1'b1;
                           shreg_nxt  = mem[rd_ptr];
                           serial_nxt = 1'b0;
                           state_nxt  = START;
                        end else begin
                           busy_nxt  = 1'b0;
                           state_nxt = IDLE;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acia_tx.sv
// Directed bench for acia_tx: per-cycle comparison against a frame-level model,
// plus hand-computed waveform checks for each scenario.
module tb_acia_tx;

   localparam int S     = 4;
   localparam int FAW   = 2;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       pclk;
   logic [7:0] tx_dat;
   logic       tx_start;
   logic       tx_serial, tx_busy, tx_empty, tx_full, tx_ovr;

   int n_checks = 0;
   int n_fail   = 0;
   bit gate     = 1'b0;
   int pc_cnt   = 0;

   acia_tx #(.SCW(9), .sym_cnt(S), .FAW(FAW)) dut (
      .clk(clk), .reset(reset), .pclk(pclk), .tx_dat(tx_dat), .tx_start(tx_start),
      .tx_serial(tx_serial), .tx_busy(tx_busy), .tx_empty(tx_empty),
      .tx_full(tx_full), .tx_ovr(tx_ovr)
   );

   always #5 clk = ~clk;

   // pclk either every clock or every 3rd clock
   always @(posedge clk) begin
      #2;
      pclk   = gate ? (pc_cnt == 0) : 1'b1;
      pc_cnt = (pc_cnt + 1) % 3;
   end

   // Model: a byte queue, and the frame in flight as a 10-bit vector indexed by enables elapsed
   logic [7:0] q[$];
   logic [9:0] frame;
   int         idx;
   bit         m_busy, m_empty, m_full, m_ovr, m_line;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         q.delete();
         m_busy = 0; m_empty = 1; m_full = 0; m_ovr = 0; m_line = 1; idx = 0;
      end else begin
         if (pclk) begin
            if (m_busy) begin
               idx++;
               if (idx == 10 * S) begin m_busy = 0; idx = 0; end
            end
            if (!m_busy && !m_empty) begin
               frame  = {1'b1, q.pop_front(), 1'b0};
               m_busy = 1;
               idx    = 0;
            end
            m_line = m_busy ? frame[idx / S] : 1'b1;
         end
         if (tx_start) begin
            if (m_full) m_ovr = 1;
            else        q.push_back(tx_dat);
         end
         m_empty = (q.size() == 0);
         m_full  = (q.size() == DEPTH);
      end
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [9:0] frame_of(logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

   task automatic write_byte(input logic [7:0] b);
      tx_dat   = b;
      tx_start = 1'b1;
      @(posedge clk);
      #2 tx_start = 1'b0;
   endtask

   task automatic wait_start(output int waited, output bit ok);
      ok = 0; waited = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (tx_serial === 1'b0) begin ok = 1; break; end
         waited++;
      end
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL start_timeout: got no start bit within 300 cycles, required one");
      end
   endtask

   task automatic check_frame(input string name, input logic [9:0] exp, input int per,
                              output int waited);
      bit ok;
      int bad, busy_n;
      wait_start(waited, ok);
      if (ok) begin
         bad = 0; busy_n = 0;
         for (int i = 0; i < 10 * per; i++) begin
            if (i > 0) @(negedge clk);
            if (tx_serial !== exp[i / per]) bad++;
            if (tx_busy === 1'b1) busy_n++;
         end
         chk({name, "_bad_bits"}, bad, 0);
         chk({name, "_busy_cycles"}, busy_n, 10 * per);
      end
   endtask

   initial begin
      int w, lows;
      reset = 1'b1; tx_start = 1'b0; tx_dat = 8'h00;
      repeat (3) @(posedge clk);
      fork
         forever begin
            @(negedge clk);
            chk("cyc_serial", tx_serial, m_line);
            chk("cyc_busy",   tx_busy,   m_busy);
            chk("cyc_empty",  tx_empty,  m_empty);
            chk("cyc_full",   tx_full,   m_full);
            chk("cyc_ovr",    tx_ovr,    m_ovr);
         end
      join_none

      @(negedge clk);
      chk("rst_serial", tx_serial, 1); chk("rst_busy", tx_busy, 0);
      chk("rst_empty", tx_empty, 1);   chk("rst_full", tx_full, 0);
      chk("rst_ovr", tx_ovr, 0);
      @(posedge clk); #2 reset = 1'b0;
      lows = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_serial !== 1'b1 || tx_busy !== 1'b0) lows++;
      end
      chk("idle_after_reset", lows, 0);

      // Single byte 0x55
      @(posedge clk); #2;
      write_byte(8'h55);
      check_frame("b55", 10'b1010101010, S, w);
      chk("b55_latency", w, 1);
      @(negedge clk);
      chk("b55_busy_after", tx_busy, 0); chk("b55_line_after", tx_serial, 1);

      // Back-to-back 0xA5, 0x3C
      @(posedge clk); #2;
      write_byte(8'hA5);
      write_byte(8'h3C);
      check_frame("bA5", 10'b1101001010, S, w);
      check_frame("b3C", frame_of(8'h3C), S, w);
      chk("b2b_gap", w, 0);

      // Full / overrun
      @(negedge clk); @(posedge clk); #2;
      fork
         begin
            for (int b = 1; b <= 6; b++) write_byte(8'(b));
            #1;
            chk("ovr_full", tx_full, 1);
            chk("ovr_flag", tx_ovr, 1);
         end
         begin
            for (int b = 1; b <= 5; b++) begin
               check_frame($sformatf("q%0d", b), frame_of(8'(b)), S, w);
               if (b > 1) chk($sformatf("q%0d_gap", b), w, 0);
            end
         end
      join
      lows = 0;
      repeat (15) begin
         @(negedge clk);
         if (tx_serial !== 1'b1) lows++;
      end
      chk("q_no_sixth", lows, 0);
      chk("ovr_sticky", tx_ovr, 1);

      // pclk every 3rd clock
      @(posedge clk); #2 gate = 1'b1;
      write_byte(8'h80);
      check_frame("g80", 10'b1100000000, 3 * S, w);
      @(posedge clk); #2 gate = 1'b0;
      repeat (4) @(posedge clk); #2;

      // Reset during data bit 3 of 0xFF with two bytes queued
      write_byte(8'hFF);
      write_byte(8'h11);
      write_byte(8'h22);
      begin
         bit ok;
         wait_start(w, ok);
      end
      repeat (4 * S) @(negedge clk);
      chk("pre_rst_busy", tx_busy, 1);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_serial", tx_serial, 1); chk("mid_rst_busy", tx_busy, 0);
      chk("mid_rst_empty", tx_empty, 1);   chk("mid_rst_ovr", tx_ovr, 0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || tx_empty !== 1'b1) lows++;
      end
      chk("post_rst_quiet", lows, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
